// File: rtl/bus_iface85.sv
// 8085-style bus interface: address/data multiplexing, strobes, status encode, PC and read capture.
// Optional HOLD/HLDA support is enabled by defining BUSIF_HOLD_EN.
module bus_iface85 (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  tstate,
   input  logic [3:0]  control,
   input  logic [2:0]  status,
   input  logic        rdy,
   input  logic [15:0] addr_in,
   input  logic        pc_load,
   input  logic [15:0] pc_din,
   input  logic [7:0]  wdata,
   input  logic [7:0]  ad_in,
   output logic [7:0]  ad_out,
   output logic        ad_oe,
   output logic [7:0]  addr_hi,
   output logic        bus_oe,
   output logic        ale,
   output logic        rd_n,
   output logic        wr_n,
   output logic        iom_n,
   output logic        s1,
   output logic        s0,
   output logic [7:0]  rdata,
   output logic        rvalid,
   output logic [15:0] pc,
   output logic        hlda
);

   localparam int unsigned AW = 16;

   localparam logic [3:0] TS_T1   = 4'd1;
   localparam logic [3:0] TS_T2   = 4'd2;
   localparam logic [3:0] TS_T3   = 4'd3;
   localparam logic [3:0] TS_HOLD = 4'd7;
   localparam logic [3:0] TS_HALT = 4'd9;
   localparam logic [3:0] TS_WAIT = 4'd10;

   logic          capture;
   logic [AW-1:0] cap_addr;
   logic          is_wait;
   logic          rd_act;
   logic          wr_act;
   logic          halted;
   logic [2:0]    stat_enc;

   // Decode of the current T-state and control strobes
   always_comb begin
      capture  = (tstate == TS_T1) && control[0];
      cap_addr = ((status == 3'd0) || (status == 3'd5)) ? pc : addr_in;
      is_wait  = (tstate == TS_WAIT);
      rd_act   = ((tstate == TS_T2) || (tstate == TS_T3) || is_wait) && control[2];
      // A simultaneous read/write request is treated as a read
      wr_act   = ((tstate == TS_T2) || (tstate == TS_T3)) && control[3] && !control[2];
`ifdef BUSIF_HOLD_EN
      halted   = (tstate == TS_HALT);
`else
      halted   = (tstate == TS_HALT) || (tstate == TS_HOLD);
`endif
      case (status)
         3'd0:    stat_enc = 3'b011;
         3'd1:    stat_enc = 3'b010;
         3'd2:    stat_enc = 3'b001;
         3'd3:    stat_enc = 3'b110;
         3'd4:    stat_enc = 3'b101;
         3'd5:    stat_enc = 3'b111;
         3'd6:    stat_enc = 3'b010;
         default: stat_enc = 3'b000;
      endcase
   end

   // Bus strobes, multiplexed AD bus, status, PC and read data
   always_ff @(posedge clock) begin
      if (reset) begin
         pc      <= 16'h0000;
         addr_hi <= 8'h00;
         ad_out  <= 8'h00;
         ad_oe   <= 1'b0;
         ale     <= 1'b0;
         rd_n    <= 1'b1;
         wr_n    <= 1'b1;
         {iom_n, s1, s0} <= 3'b011;
         rdata   <= 8'h00;
         rvalid  <= 1'b0;
      end else begin
         if (pc_load)
            pc <= pc_din;
         else if (control[1] && !halted)
            pc <= pc + 16'd1;

         rvalid <= 1'b0;
         if ((tstate == TS_T3) && control[2] && rdy) begin
            rdata  <= ad_in;
            rvalid <= 1'b1;
         end

         if (tstate == TS_T1)
            {iom_n, s1, s0} <= stat_enc;

         ale <= capture;

         if (capture) begin
            addr_hi <= cap_addr[15:8];
            ad_out  <= cap_addr[7:0];
            ad_oe   <= 1'b1;
            rd_n    <= 1'b1;
            wr_n    <= 1'b1;
         end else if (is_wait) begin
            // Wait states freeze the strobes and the AD bus exactly as they are
         end else if (rd_act) begin
            rd_n  <= 1'b0;
            wr_n  <= 1'b1;
            ad_oe <= 1'b0;
         end else if (wr_act) begin
            rd_n   <= 1'b1;
            wr_n   <= 1'b0;
            ad_out <= wdata;
            ad_oe  <= 1'b1;
         end else begin
            rd_n  <= 1'b1;
            wr_n  <= 1'b1;
            ad_oe <= 1'b0;
         end
      end
   end

`ifdef BUSIF_HOLD_EN
   // Hold acknowledge releases the bus one cycle after tstate enters hold
   always_ff @(posedge clock) begin
      if (reset) begin
         hlda   <= 1'b0;
         bus_oe <= 1'b1;
      end else begin
         hlda   <= (tstate == TS_HOLD);
         bus_oe <= (tstate != TS_HOLD);
      end
   end
`else
   assign hlda   = 1'b0;
   assign bus_oe = 1'b1;
`endif

endmodule

// File: tb/tb_bus_iface85.sv
// Directed self-checking bench for bus_iface85; hold checks follow BUSIF_HOLD_EN.
module tb_bus_iface85;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  tstate;
   logic [3:0]  control;
   logic [2:0]  status;
   logic        rdy;
   logic [15:0] addr_in;
   logic        pc_load;
   logic [15:0] pc_din;
   logic [7:0]  wdata;
   logic [7:0]  ad_in;
   logic [7:0]  ad_out;
   logic        ad_oe;
   logic [7:0]  addr_hi;
   logic        bus_oe;
   logic        ale, rd_n, wr_n, iom_n, s1, s0;
   logic [7:0]  rdata;
   logic        rvalid;
   logic [15:0] pc;
   logic        hlda;

   int nvec = 0;
   int nerr = 0;
   logic [49:0] rst_exp;

   bus_iface85 dut (
      .clock(clock), .reset(reset), .tstate(tstate), .control(control), .status(status),
      .rdy(rdy), .addr_in(addr_in), .pc_load(pc_load), .pc_din(pc_din), .wdata(wdata),
      .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .addr_hi(addr_hi), .bus_oe(bus_oe),
      .ale(ale), .rd_n(rd_n), .wr_n(wr_n), .iom_n(iom_n), .s1(s1), .s0(s0),
      .rdata(rdata), .rvalid(rvalid), .pc(pc), .hlda(hlda)
   );

   always #5 clock = ~clock;

   // Present inputs for one cycle; outputs are sampled 1 time unit after the edge
   task automatic cyc(input logic [3:0] ts, input logic [3:0] ctl);
      tstate  = ts;
      control = ctl;
      @(posedge clock);
      #1;
   endtask

   function automatic logic [49:0] snap();
      return {pc, addr_hi, ad_out, ad_oe, ale, rd_n, wr_n, iom_n, s1, s0, rdata, rvalid, hlda, bus_oe};
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      cyc(4'd0, 4'b0000);
      reset = 1'b0;
      nvec++; if (snap() !== rst_exp) begin nerr++; $display("FAIL reset_state got %h want %h", snap(), rst_exp); end
   endtask

   task automatic test_fetch();
      pc_load = 1'b1; pc_din = 16'h1234;
      cyc(4'd0, 4'b0000);
      pc_load = 1'b0;
      nvec++; if (pc !== 16'h1234) begin nerr++; $display("FAIL fetch_pcload got %h want 1234", pc); end
      status = 3'd0;
      cyc(4'd1, 4'b0001);
      nvec++; if ({ale, addr_hi, ad_out, ad_oe} !== {1'b1, 8'h12, 8'h34, 1'b1})
         begin nerr++; $display("FAIL fetch_addr got %h want 112341", {3'b0, ale, addr_hi, ad_out, 3'b0, ad_oe}); end
      nvec++; if ({iom_n, s1, s0} !== 3'b011) begin nerr++; $display("FAIL fetch_status got %b want 011", {iom_n, s1, s0}); end
      cyc(4'd2, 4'b0100);
      nvec++; if ({ale, rd_n, ad_oe, addr_hi} !== {1'b0, 1'b0, 1'b0, 8'h12})
         begin nerr++; $display("FAIL fetch_t2 got %b/%b/%b/%h want 0/0/0/12", ale, rd_n, ad_oe, addr_hi); end
      cyc(4'd4, 4'b0000);
   endtask

   task automatic test_mem_read();
      status = 3'd1; addr_in = 16'h8000; ad_in = 8'h5A; rdy = 1'b1;
      cyc(4'd1, 4'b0001);
      nvec++; if ({addr_hi, ad_out, iom_n, s1, s0} !== {8'h80, 8'h00, 3'b010})
         begin nerr++; $display("FAIL mr_addr got %h/%h/%b want 80/00/010", addr_hi, ad_out, {iom_n, s1, s0}); end
      cyc(4'd2, 4'b0100);
      nvec++; if ({rd_n, rvalid, ad_oe} !== 3'b000) begin nerr++; $display("FAIL mr_t2 got %b want 000", {rd_n, rvalid, ad_oe}); end
      cyc(4'd3, 4'b0100);
      nvec++; if ({rd_n, rvalid, rdata} !== {1'b0, 1'b1, 8'h5A})
         begin nerr++; $display("FAIL mr_t3 got %b/%b/%h want 0/1/5a", rd_n, rvalid, rdata); end
      cyc(4'd4, 4'b0000);
      nvec++; if ({rd_n, rvalid, rdata} !== {1'b1, 1'b0, 8'h5A})
         begin nerr++; $display("FAIL mr_t4 got %b/%b/%h want 1/0/5a", rd_n, rvalid, rdata); end
   endtask

   task automatic test_wait_read();
      int pulses = 0;
      int rd_hi = 0;
      status = 3'd1; addr_in = 16'h9001; ad_in = 8'h77; rdy = 1'b0;
      cyc(4'd1, 4'b0001);
      cyc(4'd2, 4'b0100);
      if (rd_n) rd_hi++;
      cyc(4'd3, 4'b0100);
      if (rd_n) rd_hi++;
      if (rvalid) pulses++;
      nvec++; if (rdata !== 8'h5A) begin nerr++; $display("FAIL wait_nocap got %h want 5a", rdata); end
      for (int i = 0; i < 2; i++) begin
         cyc(4'd10, 4'b0100);
         if (rd_n) rd_hi++;
         if (rvalid) pulses++;
      end
      rdy = 1'b1;
      cyc(4'd3, 4'b0100);
      if (rd_n) rd_hi++;
      if (rvalid) pulses++;
      nvec++; if (rdata !== 8'h77) begin nerr++; $display("FAIL wait_cap got %h want 77", rdata); end
      cyc(4'd4, 4'b0000);
      if (rvalid) pulses++;
      nvec++; if (pulses !== 1) begin nerr++; $display("FAIL wait_pulses got %0d want 1", pulses); end
      nvec++; if (rd_hi !== 0) begin nerr++; $display("FAIL wait_rdn_high got %0d want 0", rd_hi); end
      nvec++; if (rd_n !== 1'b1) begin nerr++; $display("FAIL wait_rdn_end got %b want 1", rd_n); end
   endtask

   task automatic test_io_write();
      status = 3'd4; addr_in = 16'h0042; wdata = 8'hC3;
      cyc(4'd1, 4'b0001);
      nvec++; if ({iom_n, s1, s0, addr_hi, ad_out} !== {3'b101, 8'h00, 8'h42})
         begin nerr++; $display("FAIL iow_t1 got %b/%h/%h want 101/00/42", {iom_n, s1, s0}, addr_hi, ad_out); end
      cyc(4'd2, 4'b1000);
      nvec++; if ({wr_n, rd_n, ad_oe, ad_out} !== {1'b0, 1'b1, 1'b1, 8'hC3})
         begin nerr++; $display("FAIL iow_t2 got %b/%b/%b/%h want 0/1/1/c3", wr_n, rd_n, ad_oe, ad_out); end
      wdata = 8'h11;
      cyc(4'd10, 4'b1000);
      nvec++; if ({wr_n, ad_out} !== {1'b0, 8'hC3}) begin nerr++; $display("FAIL iow_wait got %b/%h want 0/c3", wr_n, ad_out); end
      wdata = 8'hC3;
      cyc(4'd3, 4'b1000);
      nvec++; if ({wr_n, ad_oe} !== 2'b01) begin nerr++; $display("FAIL iow_t3 got %b want 01", {wr_n, ad_oe}); end
      cyc(4'd4, 4'b0000);
      nvec++; if ({wr_n, ad_oe} !== 2'b10) begin nerr++; $display("FAIL iow_t4 got %b want 10", {wr_n, ad_oe}); end
      cyc(4'd2, 4'b1100);
      nvec++; if ({wr_n, rd_n, ad_oe} !== 3'b100) begin nerr++; $display("FAIL rdwr_both got %b want 100", {wr_n, rd_n, ad_oe}); end
      cyc(4'd4, 4'b0000);
   endtask

   task automatic test_pc();
      pc_load = 1'b1; pc_din = 16'hFFFF;
      cyc(4'd4, 4'b0000);
      pc_load = 1'b0;
      cyc(4'd4, 4'b0010);
      nvec++; if (pc !== 16'h0000) begin nerr++; $display("FAIL pc_wrap got %h want 0000", pc); end
      pc_load = 1'b1; pc_din = 16'hABCD;
      cyc(4'd4, 4'b0010);
      pc_load = 1'b0;
      nvec++; if (pc !== 16'hABCD) begin nerr++; $display("FAIL pc_load_prio got %h want abcd", pc); end
      cyc(4'd4, 4'b0010);
      nvec++; if (pc !== 16'hABCE) begin nerr++; $display("FAIL pc_inc got %h want abce", pc); end
      cyc(4'd9, 4'b1110);
      nvec++; if ({pc, rd_n, wr_n, ale, ad_oe} !== {16'hABCE, 4'b1100})
         begin nerr++; $display("FAIL halt got %h/%b want abce/1100", pc, {rd_n, wr_n, ale, ad_oe}); end
      pc_load = 1'b1; pc_din = 16'h0100;
      cyc(4'd9, 4'b0010);
      pc_load = 1'b0;
      nvec++; if (pc !== 16'h0100) begin nerr++; $display("FAIL halt_load got %h want 0100", pc); end
   endtask

   task automatic test_hold();
`ifdef BUSIF_HOLD_EN
      for (int i = 0; i < 3; i++) begin
         cyc(4'd7, 4'b0100);
         nvec++; if ({hlda, bus_oe, ad_oe, rd_n, wr_n, ale} !== 6'b100110)
            begin nerr++; $display("FAIL hold_%0d got %b want 100110", i, {hlda, bus_oe, ad_oe, rd_n, wr_n, ale}); end
      end
      status = 3'd1;
      cyc(4'd1, 4'b0001);
      nvec++; if ({hlda, bus_oe} !== 2'b01) begin nerr++; $display("FAIL hold_exit got %b want 01", {hlda, bus_oe}); end
      cyc(4'd7, 4'b0000);
      reset = 1'b1;
      cyc(4'd7, 4'b0000);
      reset = 1'b0;
      nvec++; if ({hlda, bus_oe} !== 2'b01) begin nerr++; $display("FAIL hold_reset got %b want 01", {hlda, bus_oe}); end
`else
      pc_load = 1'b1; pc_din = 16'h2000;
      cyc(4'd4, 4'b0000);
      pc_load = 1'b0;
      cyc(4'd7, 4'b0110);
      nvec++; if ({pc, hlda, bus_oe, rd_n, ale, ad_oe} !== {16'h2000, 5'b01100})
         begin nerr++; $display("FAIL hold_as_halt got %h/%b want 2000/01100", pc, {hlda, bus_oe, rd_n, ale, ad_oe}); end
`endif
   endtask

   task automatic test_reset_mid();
      status = 3'd1; addr_in = 16'h4321; ad_in = 8'hEE; rdy = 1'b1;
      pc_load = 1'b1; pc_din = 16'h5555;
      cyc(4'd1, 4'b0011);
      pc_load = 1'b0;
      cyc(4'd2, 4'b0100);
      nvec++; if (rd_n !== 1'b0) begin nerr++; $display("FAIL mid_pre got %b want 0", rd_n); end
      reset = 1'b1;
      cyc(4'd3, 4'b0110);
      reset = 1'b0;
      nvec++; if (snap() !== rst_exp) begin nerr++; $display("FAIL mid_reset got %h want %h", snap(), rst_exp); end
   endtask

   initial begin
      rst_exp = {16'h0000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 3'b011, 8'h00, 1'b0, 1'b0, 1'b1};
      reset = 1'b1; tstate = 4'd0; control = 4'd0; status = 3'd0; rdy = 1'b0;
      addr_in = 16'h0; pc_load = 1'b0; pc_din = 16'h0; wdata = 8'h0; ad_in = 8'h0;
      test_reset();
      test_fetch();
      test_mem_read();
      test_wait_read();
      test_io_write();
      test_pc();
      test_hold();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
